// File: rtl/alu_operand_stage.sv
// ID/EX stage ahead of the 32-bit ALU: decodes a MIPS integer instruction into a/b/aluc/wr_*.
// One-cycle latency into a valid/ready output register; holds data while out_ready is low.
module alu_operand_stage #(
  parameter int DW  = 32,
  parameter int RAW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [31:0]    instr,
  input  logic [DW-1:0]  rs_data,
  input  logic [DW-1:0]  rt_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  a,
  output logic [DW-1:0]  b,
  output logic [3:0]     aluc,
  output logic [RAW-1:0] wr_addr,
  output logic           wr_en,
  output logic           illegal
);

  typedef struct packed {
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [3:0]     aluc;
    logic [RAW-1:0] wr_addr;
    logic           wr_en;
    logic           illegal;
  } ex_t;

  localparam logic [3:0] ALU_ADDU = 4'b0000;
  localparam logic [3:0] ALU_SUBU = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SLL  = 4'b1110;

  logic [5:0]    op;
  logic [5:0]    funct;
  logic [15:0]   imm;
  logic [DW-1:0] imm_sext;
  logic [DW-1:0] imm_zext;
  logic [DW-1:0] shamt_imm;
  logic [DW-1:0] shamt_reg;
  logic          unused_rs_field;

  assign op        = instr[31:26];
  assign funct     = instr[5:0];
  assign imm       = instr[15:0];
  assign imm_sext  = {{(DW-16){imm[15]}}, imm};
  assign imm_zext  = {{(DW-16){1'b0}}, imm};
  assign shamt_imm = {{(DW-5){1'b0}}, instr[10:6]};
  assign shamt_reg = {{(DW-5){1'b0}}, rs_data[4:0]};
  // rs arrives already resolved as rs_data, so the address field itself is not needed here.
  assign unused_rs_field = ^instr[25:21];

  ex_t  dec;
  logic dec_ok;

  always_comb begin
    dec    = '0;
    dec_ok = 1'b1;
    if (op == 6'b000000) begin
      dec.wr_addr = instr[15:11];
      dec.a       = rs_data;
      dec.b       = rt_data;
      case (funct)
        6'b100000: dec.aluc = ALU_ADD;
        6'b100001: dec.aluc = ALU_ADDU;
        6'b100010: dec.aluc = ALU_SUB;
        6'b100011: dec.aluc = ALU_SUBU;
        6'b100100: dec.aluc = ALU_AND;
        6'b100101: dec.aluc = ALU_OR;
        6'b100110: dec.aluc = ALU_XOR;
        6'b100111: dec.aluc = ALU_NOR;
        6'b101010: dec.aluc = ALU_SLT;
        6'b101011: dec.aluc = ALU_SLTU;
        6'b000000: begin dec.aluc = ALU_SLL; dec.a = shamt_imm; end
        6'b000010: begin dec.aluc = ALU_SRL; dec.a = shamt_imm; end
        6'b000011: begin dec.aluc = ALU_SRA; dec.a = shamt_imm; end
        6'b000100: begin dec.aluc = ALU_SLL; dec.a = shamt_reg; end
        6'b000110: begin dec.aluc = ALU_SRL; dec.a = shamt_reg; end
        6'b000111: begin dec.aluc = ALU_SRA; dec.a = shamt_reg; end
        default:   dec_ok = 1'b0;
      endcase
    end else begin
      dec.wr_addr = instr[20:16];
      dec.a       = rs_data;
      case (op)
        6'b001000: begin dec.aluc = ALU_ADD;  dec.b = imm_sext; end
        6'b001001: begin dec.aluc = ALU_ADDU; dec.b = imm_sext; end
        6'b001010: begin dec.aluc = ALU_SLT;  dec.b = imm_sext; end
        6'b001011: begin dec.aluc = ALU_SLTU; dec.b = imm_sext; end
        6'b001100: begin dec.aluc = ALU_AND;  dec.b = imm_zext; end
        6'b001101: begin dec.aluc = ALU_OR;   dec.b = imm_zext; end
        6'b001110: begin dec.aluc = ALU_XOR;  dec.b = imm_zext; end
        6'b001111: begin dec.aluc = ALU_LUI;  dec.a = '0; dec.b = imm_zext; end
        default:   dec_ok = 1'b0;
      endcase
    end
    // Unsupported encodings still flow through the pipe, but as a harmless zeroed bubble.
    if (!dec_ok) begin
      dec.a    = '0;
      dec.b    = '0;
      dec.aluc = 4'b0000;
    end
    dec.illegal = ~dec_ok;
    dec.wr_en   = dec_ok & (dec.wr_addr != '0);
  end

  ex_t  held;
  logic load;

  assign in_ready = ~out_valid | out_ready;
  assign load     = in_valid & in_ready & ~flush;

  // Flush only drops valid; the data register keeps its stale contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      held      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      held      <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign a       = held.a;
  assign b       = held.b;
  assign aluc    = held.aluc;
  assign wr_addr = held.wr_addr;
  assign wr_en   = held.wr_en;
  assign illegal = held.illegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed decode cases, stall/flush/reset scenarios, random stream.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  aluc;
  logic [4:0]  wr_addr;
  logic        wr_en;
  logic        illegal;

  int total = 0;
  int bad = 0;

  alu_operand_stage #(.DW(32), .RAW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .aluc(aluc), .wr_addr(wr_addr), .wr_en(wr_en), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluc;
    logic [4:0]  wa;
    logic        we;
    logic        ill;
  } exp_t;

  localparam logic [5:0] RFUN [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                      6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
  localparam logic [5:0] IOPS [8]  = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};

  // Reference: classify the instruction into an operand "kind", then build operands arithmetically.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    int kind;
    int code;
    logic [31:0] imm;
    kind = -1;
    code = 0;
    imm  = 32'(ins[15:0]);
    if (ins[31:26] == 6'd0) begin
      case (ins[5:0])
        6'h20: begin code = 2;  kind = 0; end
        6'h21: begin code = 0;  kind = 0; end
        6'h22: begin code = 3;  kind = 0; end
        6'h23: begin code = 1;  kind = 0; end
        6'h24: begin code = 4;  kind = 0; end
        6'h25: begin code = 5;  kind = 0; end
        6'h26: begin code = 6;  kind = 0; end
        6'h27: begin code = 7;  kind = 0; end
        6'h2A: begin code = 11; kind = 0; end
        6'h2B: begin code = 10; kind = 0; end
        6'h00: begin code = 14; kind = 1; end
        6'h02: begin code = 13; kind = 1; end
        6'h03: begin code = 12; kind = 1; end
        6'h04: begin code = 14; kind = 2; end
        6'h06: begin code = 13; kind = 2; end
        6'h07: begin code = 12; kind = 2; end
        default: kind = -1;
      endcase
    end else begin
      case (ins[31:26])
        6'h08: begin code = 2;  kind = 3; end
        6'h09: begin code = 0;  kind = 3; end
        6'h0A: begin code = 11; kind = 3; end
        6'h0B: begin code = 10; kind = 3; end
        6'h0C: begin code = 4;  kind = 4; end
        6'h0D: begin code = 5;  kind = 4; end
        6'h0E: begin code = 6;  kind = 4; end
        6'h0F: begin code = 8;  kind = 5; end
        default: kind = -1;
      endcase
    end
    e = '0;
    e.wa = (ins[31:26] == 6'd0) ? ins[15:11] : ins[20:16];
    case (kind)
      0: begin e.a = rs; e.b = rt; end
      1: begin e.a = 32'(ins[10:6]); e.b = rt; end
      2: begin e.a = rs % 32; e.b = rt; end
      3: begin e.a = rs; e.b = ins[15] ? imm - 32'h10000 : imm; end
      4: begin e.a = rs; e.b = imm; end
      5: begin e.a = 0; e.b = imm; end
      default: e.ill = 1'b1;
    endcase
    e.aluc = 4'(code);
    e.we   = (kind >= 0) && (e.wa != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(24);
    if (k < 16) begin
      w[31:26] = 6'd0;
      w[5:0] = RFUN[k];
    end else if (k < 24) begin
      w[31:26] = IOPS[k-16];
    end
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #3;
    total++;
    if ({out_valid, a, b, aluc, wr_addr, wr_en, illegal, in_ready} !== {1'b0, 76'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset: got v=%b a=%h b=%h aluc=%h wa=%0d we=%b ill=%b rdy=%b, want all zero and rdy=1",
               out_valid, a, b, aluc, wr_addr, wr_en, illegal, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] t_ins [8] = '{32'h00221821, 32'h00052100, 32'h00273007, 32'h2002FFFF,
                               32'h3002FFFF, 32'h3C021234, 32'h00220020, 32'hFC000000};
    logic [31:0] t_rs  [8] = '{32'd5, 32'hDEAD, 32'h23, 32'd0, 32'd0, 32'h55, 32'd1, 32'd9};
    logic [31:0] t_rt  [8] = '{32'd7, 32'd1, 32'h80000000, 32'd3, 32'd3, 32'd4, 32'd2, 32'd9};
    logic [31:0] x_a   [8] = '{32'd5, 32'd4, 32'd3, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0};
    logic [31:0] x_b   [8] = '{32'd7, 32'd1, 32'h80000000, 32'hFFFFFFFF, 32'h0000FFFF,
                               32'h00001234, 32'd2, 32'd0};
    logic [3:0]  x_c   [8] = '{4'h0, 4'hE, 4'hC, 4'h2, 4'h4, 4'h8, 4'h2, 4'h0};
    logic [4:0]  x_wa  [8] = '{5'd3, 5'd4, 5'd6, 5'd2, 5'd2, 5'd2, 5'd0, 5'd0};
    logic        x_we  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        x_il  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      instr = t_ins[i]; rs_data = t_rs[i]; rt_data = t_rt[i];
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      total++;
      if ({out_valid, a, b, aluc, wr_en, illegal} !== {1'b1, x_a[i], x_b[i], x_c[i], x_we[i], x_il[i]}) begin
        bad++;
        $display("FAIL directed[%0d] %h: got v=%b a=%h b=%h aluc=%h we=%b ill=%b, want v=1 a=%h b=%h aluc=%h we=%b ill=%b",
                 i, t_ins[i], out_valid, a, b, aluc, wr_en, illegal, x_a[i], x_b[i], x_c[i], x_we[i], x_il[i]);
      end
      if (!x_il[i]) begin
        total++;
        if (wr_addr !== x_wa[i]) begin
          bad++;
          $display("FAIL directed_waddr[%0d]: got %0d want %0d", i, wr_addr, x_wa[i]);
        end
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stall();
    logic [31:0] ia, ib;
    exp_t ea, eb;
    ia = 32'h00221821; ib = 32'h00852022;
    ea = model(ia, 32'd11, 32'd22);
    eb = model(ib, 32'd100, 32'd40);
    @(negedge clk);
    instr = ia; rs_data = 32'd11; rt_data = 32'd22; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    instr = ib; rs_data = 32'd100; rt_data = 32'd40; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      total++;
      if ({in_ready, out_valid, a, b, aluc} !== {1'b0, 1'b1, ea.a, ea.b, ea.aluc}) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got rdy=%b v=%b a=%h b=%h aluc=%h, want rdy=0 v=1 a=%h b=%h aluc=%h",
                 c, in_ready, out_valid, a, b, aluc, ea.a, ea.b, ea.aluc);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_release_rdy: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++;
    if ({out_valid, a, b, aluc, wr_addr} !== {1'b1, eb.a, eb.b, eb.aluc, eb.wa}) begin
      bad++;
      $display("FAIL stall_next: got v=%b a=%h b=%h aluc=%h wa=%0d, want v=1 a=%h b=%h aluc=%h wa=%0d",
               out_valid, a, b, aluc, wr_addr, eb.a, eb.b, eb.aluc, eb.wa);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_flush();
    @(negedge clk);
    instr = 32'h00221821; rs_data = 32'd1; rt_data = 32'd2; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    instr = 32'h3C021234; out_ready = 1'b0; flush = 1'b1;
    #1;
    total++;
    if ({out_valid, in_ready} !== 2'b10) begin
      bad++;
      $display("FAIL flush_pre: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL flush_kill: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    // Flush on an empty stage must still drop the incoming instruction.
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_empty: got v=%b want 0", out_valid);
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_drop: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_stream(input string name, input int cycles, input int pv, input int pr,
                             input int want_loads);
    exp_t q[$];
    exp_t e;
    int loads;
    bit acc;
    loads = 0;
    for (int c = 0; c < cycles + 20; c++) begin
      @(negedge clk);
      in_valid  = (c < cycles) && ($urandom_range(99) < pv);
      out_ready = (c >= cycles) || ($urandom_range(99) < pr);
      instr   = rand_instr();
      rs_data = $urandom;
      rt_data = $urandom;
      #1;
      total++;
      if (out_valid !== (q.size() != 0)) begin
        bad++;
        $display("FAIL %s_valid@%0d: got %b want %b", name, c, out_valid, q.size() != 0);
      end
      total++;
      if (in_ready !== ((q.size() == 0) || out_ready)) begin
        bad++;
        $display("FAIL %s_ready@%0d: got %b want %b", name, c, in_ready, (q.size() == 0) || out_ready);
      end
      acc = in_valid && ((q.size() == 0) || out_ready);
      if (q.size() != 0 && out_ready) begin
        e = q.pop_front();
        total++;
        if ({a, b, aluc, wr_en, illegal} !== {e.a, e.b, e.aluc, e.we, e.ill} || (!e.ill && wr_addr !== e.wa)) begin
          bad++;
          $display("FAIL %s_data@%0d: got a=%h b=%h aluc=%h wa=%0d we=%b ill=%b want a=%h b=%h aluc=%h wa=%0d we=%b ill=%b",
                   name, c, a, b, aluc, wr_addr, wr_en, illegal, e.a, e.b, e.aluc, e.wa, e.we, e.ill);
        end
      end
      if (acc) begin
        q.push_back(model(instr, rs_data, rt_data));
        loads++;
      end
    end
    in_valid = 1'b0;
    total++;
    if (q.size() != 0 || (want_loads >= 0 && loads != want_loads)) begin
      bad++;
      $display("FAIL %s_count: pending=%0d loads=%0d want pending=0 loads=%0d", name, q.size(), loads, want_loads);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    instr = 32'h00221821; rs_data = 32'd5; rt_data = 32'd7; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++;
    if ({out_valid, a, b} !== {1'b1, 32'd5, 32'd7}) begin
      bad++;
      $display("FAIL areset_pre: got v=%b a=%h b=%h want v=1 a=5 b=7", out_valid, a, b);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, a, b, aluc, wr_addr, wr_en, illegal, in_ready} !== {1'b0, 76'd0, 1'b1}) begin
      bad++;
      $display("FAIL areset: got v=%b a=%h b=%h aluc=%h wa=%0d we=%b ill=%b rdy=%b, want zeros and rdy=1",
               out_valid, a, b, aluc, wr_addr, wr_en, illegal, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_flush();
    test_stream("back_to_back", 8, 100, 100, 8);
    test_stream("stream", 60, 80, 50, -1);
    test_stream("random", 300, 60, 60, -1);
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
